shapool_ctrl: RTL and testbench

Job sequencer between the SPI job loader and the hashing pool in the top-level design. Waits for PLL lock, starts the pool on each loaded job, and steps the nonce base by POOL_SIZE per round. Stops on success, nonce-space exhaustion, or round timeout, and raises the READY flag and status LED. Runs entirely in the PLL clock domain; inputs arrive already synchronised.

---
 rtl/shapool_ctrl.sv | 167 ++++++++++++++++
 tb/tb_shapool_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/shapool_ctrl.sv
// Job sequencer between the SPI job loader and the hashing pool: waits for PLL lock,
// launches rounds at successive nonce bases and reports success, exhaustion or timeout.
module shapool_ctrl #(
   parameter int POOL_SIZE      = 1,
   parameter int POOL_SIZE_LOG2 = 0,
   parameter int NONCE_WIDTH    = 32,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int LED_DIV_BITS   = 22
) (
   input  logic                   clk_in,
   input  logic                   reset_n_in,
   input  logic                   pll_locked_in,
   input  logic                   job_valid_in,
   input  logic                   halt_in,
   input  logic                   round_done_in,
   input  logic                   success_in,
   output logic                   pool_start_out,
   output logic [NONCE_WIDTH-1:0] nonce_out,
   output logic                   busy_out,
   output logic                   success_out,
   output logic                   exhausted_out,
   output logic                   error_out,
   output logic                   ready_n_out,
   output logic                   status_led_n_out
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [NONCE_WIDTH-1:0] NONCE_STEP = NONCE_WIDTH'(1) << POOL_SIZE_LOG2;
   // Base of the final round: 2^NONCE_WIDTH - POOL_SIZE, valid because POOL_SIZE is a power of two
   localparam logic [NONCE_WIDTH-1:0] LAST_NONCE = ~(NONCE_WIDTH'(POOL_SIZE - 1));

   typedef enum logic [2:0] {
      WAIT_LOCK,
      IDLE,
      START,
      RUN,
      DONE,
      ERROR
   } state_t;

   state_t                  state, state_next;
   logic [NONCE_WIDTH-1:0]  nonce_next;
   logic                    success_next, exhausted_next, error_next;
   logic                    pool_start_next, busy_next, ready_n_next, led_n_next;
   logic [TW-1:0]           tmo_cnt, tmo_next;
   logic [LED_DIV_BITS-1:0] blink_cnt, blink_next;

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state            <= WAIT_LOCK;
         nonce_out        <= '0;
         pool_start_out   <= 1'b0;
         busy_out         <= 1'b0;
         success_out      <= 1'b0;
         exhausted_out    <= 1'b0;
         error_out        <= 1'b0;
         ready_n_out      <= 1'b1;
         status_led_n_out <= 1'b1;
         tmo_cnt          <= '0;
         blink_cnt        <= '0;
      end else begin
         state            <= state_next;
         nonce_out        <= nonce_next;
         pool_start_out   <= pool_start_next;
         busy_out         <= busy_next;
         success_out      <= success_next;
         exhausted_out    <= exhausted_next;
         error_out        <= error_next;
         ready_n_out      <= ready_n_next;
         status_led_n_out <= led_n_next;
         tmo_cnt          <= tmo_next;
         blink_cnt        <= blink_next;
      end
   end

   // Outputs are registered from the next-state values so they line up with the state they describe
   always_comb begin
      state_next      = state;
      nonce_next      = nonce_out;
      success_next    = success_out;
      exhausted_next  = exhausted_out;
      error_next      = error_out;
      tmo_next        = tmo_cnt;
      blink_next      = blink_cnt + 1'b1;
      pool_start_next = 1'b0;
      busy_next       = 1'b0;
      ready_n_next    = 1'b1;
      led_n_next      = 1'b1;

      if (!pll_locked_in) begin
         state_next     = WAIT_LOCK;
         nonce_next     = '0;
         success_next   = 1'b0;
         exhausted_next = 1'b0;
         error_next     = 1'b0;
         tmo_next       = '0;
         blink_next     = '0;
      end else if (halt_in && state != WAIT_LOCK) begin
         state_next     = IDLE;
         nonce_next     = '0;
         success_next   = 1'b0;
         exhausted_next = 1'b0;
         error_next     = 1'b0;
      end else begin
         case (state)
            WAIT_LOCK: state_next = IDLE;
            IDLE, DONE, ERROR: begin
               if (job_valid_in) begin
                  state_next     = START;
                  nonce_next     = '0;
                  success_next   = 1'b0;
                  exhausted_next = 1'b0;
                  error_next     = 1'b0;
                  blink_next     = '0;
               end
            end
            START: begin
               state_next = RUN;
               tmo_next   = '0;
            end
            RUN: begin
               tmo_next = tmo_cnt + 1'b1;
               // A fresh job overrides whatever the pool reports in the same cycle
               if (job_valid_in) begin
                  state_next = START;
                  nonce_next = '0;
               end else if (round_done_in) begin
                  if (success_in) begin
                     state_next   = DONE;
                     success_next = 1'b1;
                  end else if (nonce_out == LAST_NONCE) begin
                     state_next     = DONE;
                     exhausted_next = 1'b1;
                  end else begin
                     state_next = START;
                     nonce_next = nonce_out + NONCE_STEP;
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  state_next = ERROR;
                  error_next = 1'b1;
               end
            end
            default: state_next = WAIT_LOCK;
         endcase
      end

      pool_start_next = (state_next == START);
      busy_next       = (state_next == START) || (state_next == RUN);
      ready_n_next    = !((state_next == DONE) || (state_next == ERROR));

      case (state_next)
         START, RUN: led_n_next = ~blink_next[LED_DIV_BITS-1];
         DONE: begin
            if (success_next)
               led_n_next = 1'b0;
            else if (exhausted_next)
               led_n_next = blink_next[LED_DIV_BITS-3];
            else
               led_n_next = 1'b1;
         end
         ERROR:   led_n_next = blink_next[LED_DIV_BITS-3];
         default: led_n_next = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_shapool_ctrl.sv
// Directed bench for shapool_ctrl: two instances share stimulus, one with a single core and
// 32-bit nonces, one with four cores and a 4-bit nonce space so exhaustion is reachable.
module tb_shapool_ctrl;

   logic clk = 1'b0;
   logic reset_n, pll_locked, job_valid, halt, round_done, success_in;

   logic        pool_start_a, busy_a, success_a, exhausted_a, error_a, ready_n_a, led_a;
   logic [31:0] nonce_a;
   logic        pool_start_b, busy_b, success_b, exhausted_b, error_b, ready_n_b, led_b;
   logic [3:0]  nonce_b;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   shapool_ctrl #(
      .POOL_SIZE(1), .POOL_SIZE_LOG2(0), .NONCE_WIDTH(32),
      .TIMEOUT_CYCLES(16), .LED_DIV_BITS(4)
   ) dut_a (
      .clk_in(clk), .reset_n_in(reset_n), .pll_locked_in(pll_locked),
      .job_valid_in(job_valid), .halt_in(halt), .round_done_in(round_done),
      .success_in(success_in), .pool_start_out(pool_start_a), .nonce_out(nonce_a),
      .busy_out(busy_a), .success_out(success_a), .exhausted_out(exhausted_a),
      .error_out(error_a), .ready_n_out(ready_n_a), .status_led_n_out(led_a)
   );

   shapool_ctrl #(
      .POOL_SIZE(4), .POOL_SIZE_LOG2(2), .NONCE_WIDTH(4),
      .TIMEOUT_CYCLES(16), .LED_DIV_BITS(4)
   ) dut_b (
      .clk_in(clk), .reset_n_in(reset_n), .pll_locked_in(pll_locked),
      .job_valid_in(job_valid), .halt_in(halt), .round_done_in(round_done),
      .success_in(success_in), .pool_start_out(pool_start_b), .nonce_out(nonce_b),
      .busy_out(busy_b), .success_out(success_b), .exhausted_out(exhausted_b),
      .error_out(error_b), .ready_n_out(ready_n_b), .status_led_n_out(led_b)
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start_job();
      job_valid = 1'b1;
      step(1);
      job_valid = 1'b0;
   endtask

   // From START: one cycle into RUN, four more, then a round_done pulse
   task automatic run_round(input bit hit);
      step(5);
      round_done = 1'b1;
      success_in = hit;
      step(1);
      round_done = 1'b0;
      success_in = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; pll_locked = 1'b0; job_valid = 1'b0;
      halt = 1'b0; round_done = 1'b0; success_in = 1'b0;
      step(2);
      total++; if ({pool_start_a, busy_a, success_a, exhausted_a, error_a, ready_n_a, led_a} !== 7'b0000011)
         $display("FAIL reset_flags_a: got %b expected 0000011", {pool_start_a, busy_a, success_a, exhausted_a, error_a, ready_n_a, led_a}); else passed++;
      total++; if (nonce_a !== 32'd0) $display("FAIL reset_nonce_a: got %0d expected 0", nonce_a); else passed++;
      reset_n = 1'b1;
      // Job pulses while unlocked must be ignored
      step(4);
      start_job();
      step(3);
      total++; if ({pool_start_b, busy_b, ready_n_b, led_b} !== 4'b0011)
         $display("FAIL waitlock_b: got %b expected 0011", {pool_start_b, busy_b, ready_n_b, led_b}); else passed++;
      pll_locked = 1'b1;
      step(1);
      total++; if ({pool_start_a, busy_a, ready_n_a, led_a} !== 4'b0011)
         $display("FAIL idle_a: got %b expected 0011", {pool_start_a, busy_a, ready_n_a, led_a}); else passed++;
      total++; if (nonce_a !== 32'd0) $display("FAIL idle_nonce_a: got %0d expected 0", nonce_a); else passed++;
   endtask

   task automatic test_success();
      logic [31:0] bl;
      start_job();
      for (int r = 0; r < 4; r++) begin
         bl = 32'(6 * r);
         total++; if (pool_start_a !== 1'b1) $display("FAIL start_a_r%0d: got %b expected 1", r, pool_start_a); else passed++;
         total++; if (nonce_a !== 32'(r)) $display("FAIL nonce_a_r%0d: got %0d expected %0d", r, nonce_a, r); else passed++;
         total++; if (nonce_b !== 4'(4 * r)) $display("FAIL nonce_b_r%0d: got %0d expected %0d", r, nonce_b, 4 * r); else passed++;
         total++; if (led_a !== ~bl[3]) $display("FAIL led_run_a_r%0d: got %b expected %b", r, led_a, ~bl[3]); else passed++;
         step(1);
         total++; if ({pool_start_a, busy_a} !== 2'b01) $display("FAIL run_a_r%0d: got %b expected 01", r, {pool_start_a, busy_a}); else passed++;
         step(4);
         round_done = 1'b1;
         success_in = (r == 3);
         step(1);
         round_done = 1'b0;
         success_in = 1'b0;
      end
      step(3);
      total++; if ({success_a, ready_n_a, led_a, busy_a} !== 4'b1000)
         $display("FAIL done_success_a: got %b expected 1000", {success_a, ready_n_a, led_a, busy_a}); else passed++;
      total++; if (nonce_a !== 32'd3) $display("FAIL done_nonce_a: got %0d expected 3", nonce_a); else passed++;
      total++; if ({success_b, exhausted_b, nonce_b} !== {2'b10, 4'd12})
         $display("FAIL success_over_exhaust_b: got %b expected 101100", {success_b, exhausted_b, nonce_b}); else passed++;
   endtask

   task automatic test_exhaust();
      logic [31:0] bl;
      start_job();
      total++; if ({success_b, ready_n_b} !== 2'b01) $display("FAIL job_clears_b: got %b expected 01", {success_b, ready_n_b}); else passed++;
      for (int r = 0; r < 4; r++) begin
         bl = 32'(6 * r);
         total++; if ({pool_start_b, nonce_b} !== {1'b1, 4'(4 * r)})
            $display("FAIL exh_start_b_r%0d: got %b expected %b", r, {pool_start_b, nonce_b}, {1'b1, 4'(4 * r)}); else passed++;
         total++; if (led_b !== ~bl[3]) $display("FAIL led_run_b_r%0d: got %b expected %b", r, led_b, ~bl[3]); else passed++;
         run_round(1'b0);
      end
      total++; if ({exhausted_b, success_b, ready_n_b, busy_b, nonce_b} !== {4'b1000, 4'd12})
         $display("FAIL exhausted_b: got %b expected 10001100", {exhausted_b, success_b, ready_n_b, busy_b, nonce_b}); else passed++;
      total++; if ({pool_start_a, exhausted_a, nonce_a} !== {2'b10, 32'd4})
         $display("FAIL not_exhausted_a: got ps=%b ex=%b nonce=%0d expected 1 0 4", pool_start_a, exhausted_a, nonce_a); else passed++;
      for (int i = 0; i < 4; i++) begin
         bl = 32'(24 + i);
         total++; if (led_b !== bl[1]) $display("FAIL led_exh_b_%0d: got %b expected %b", i, led_b, bl[1]); else passed++;
         if (i < 3) step(1);
      end
   endtask

   task automatic test_timeout();
      start_job();
      total++; if ({pool_start_b, exhausted_b, nonce_b} !== {2'b10, 4'd0})
         $display("FAIL tmo_start_b: got %b expected 100000", {pool_start_b, exhausted_b, nonce_b}); else passed++;
      step(16);
      total++; if ({error_b, busy_b, ready_n_b} !== 3'b011)
         $display("FAIL tmo_early_b: got %b expected 011", {error_b, busy_b, ready_n_b}); else passed++;
      step(1);
      total++; if ({error_b, busy_b, ready_n_b, led_b} !== 4'b1000)
         $display("FAIL tmo_error_b: got %b expected 1000", {error_b, busy_b, ready_n_b, led_b}); else passed++;
      total++; if (error_a !== 1'b1) $display("FAIL tmo_error_a: got %b expected 1", error_a); else passed++;
      step(1);
      total++; if (led_b !== 1'b1) $display("FAIL led_err_b: got %b expected 1", led_b); else passed++;
      start_job();
      total++; if ({error_b, ready_n_b, pool_start_b, nonce_b} !== {3'b011, 4'd0})
         $display("FAIL tmo_restart_b: got %b expected 0110000", {error_b, ready_n_b, pool_start_b, nonce_b}); else passed++;
      total++; if ({error_a, nonce_a} !== {1'b0, 32'd0})
         $display("FAIL tmo_restart_a: got err=%b nonce=%0d expected 0 0", error_a, nonce_a); else passed++;
   endtask

   task automatic test_back_to_back();
      run_round(1'b0);
      run_round(1'b0);
      total++; if (nonce_a !== 32'd2) $display("FAIL b2b_setup_a: got %0d expected 2", nonce_a); else passed++;
      step(3);
      round_done = 1'b1;
      success_in = 1'b1;
      job_valid  = 1'b1;
      step(1);
      round_done = 1'b0;
      success_in = 1'b0;
      job_valid  = 1'b0;
      total++; if ({pool_start_a, success_a, busy_a, nonce_a} !== {3'b101, 32'd0})
         $display("FAIL b2b_restart_a: got ps=%b s=%b busy=%b nonce=%0d expected 1 0 1 0", pool_start_a, success_a, busy_a, nonce_a); else passed++;
      total++; if (nonce_b !== 4'd0) $display("FAIL b2b_restart_b: got %0d expected 0", nonce_b); else passed++;
      step(1);
      total++; if ({success_a, ready_n_a} !== 2'b01) $display("FAIL b2b_run_a: got %b expected 01", {success_a, ready_n_a}); else passed++;
   endtask

   task automatic test_halt_pll();
      step(2);
      halt = 1'b1;
      step(1);
      halt = 1'b0;
      total++; if ({pool_start_a, busy_a, ready_n_a, led_a, nonce_a} !== {4'b0011, 32'd0})
         $display("FAIL halt_run_a: got ps=%b busy=%b rdy=%b led=%b nonce=%0d expected 0 0 1 1 0", pool_start_a, busy_a, ready_n_a, led_a, nonce_a); else passed++;
      start_job();
      run_round(1'b1);
      total++; if ({success_a, ready_n_a} !== 2'b10) $display("FAIL halt_setup_a: got %b expected 10", {success_a, ready_n_a}); else passed++;
      halt = 1'b1;
      step(1);
      halt = 1'b0;
      total++; if ({success_a, ready_n_a, led_a} !== 3'b011) $display("FAIL halt_done_a: got %b expected 011", {success_a, ready_n_a, led_a}); else passed++;
      start_job();
      run_round(1'b1);
      pll_locked = 1'b0;
      step(1);
      total++; if ({pool_start_a, busy_a, success_a, exhausted_a, error_a, ready_n_a, led_a} !== 7'b0000011)
         $display("FAIL pll_loss_a: got %b expected 0000011", {pool_start_a, busy_a, success_a, exhausted_a, error_a, ready_n_a, led_a}); else passed++;
      total++; if ({success_b, ready_n_b, nonce_b} !== {2'b01, 4'd0})
         $display("FAIL pll_loss_b: got %b expected 010000", {success_b, ready_n_b, nonce_b}); else passed++;
      // Lock and a job arriving together: the job is dropped because the sequencer is still in WAIT_LOCK
      pll_locked = 1'b1;
      job_valid  = 1'b1;
      step(1);
      job_valid = 1'b0;
      total++; if ({pool_start_a, busy_a} !== 2'b00) $display("FAIL relock_a: got %b expected 00", {pool_start_a, busy_a}); else passed++;
   endtask

   initial begin
      test_reset();
      test_success();
      test_exhaust();
      test_timeout();
      test_back_to_back();
      test_halt_pll();
      $display("[TB] %0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
